// File: rtl/render_pkg.sv
// Shared types and pixel-mux select encoding for the render scheduler.
package render_pkg;

  typedef enum logic [3:0] {
    MENU,
    WAIT_REL,
    LOAD_RECIPE,
    ERASE,
    LAYER,
    GAP,
    CHECK,
    FRAME_WAIT,
    SHIFT,
    SCORE,
    HOLD,
    OVER
  } state_t;

  localparam int unsigned SEL_ERASE = 0;

  function automatic int unsigned sel_layer(input int unsigned i);
    return i + 1;
  endfunction

  function automatic int unsigned sel_score(input int unsigned n);
    return n + 1;
  endfunction

  function automatic int unsigned sel_over(input int unsigned n);
    return n + 2;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running modulo-TICK_DIV counter; tick is high while the count is 0.
module tick_divider #(
  parameter int unsigned TICK_DIV = 833334
) (
  input  logic clk,
  input  logic resetn,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  assign wrap = (cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= wrap;
      cnt  <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/render_scheduler.sv
// Game sequencer: menu, recipe load, per-frame erase/layer draw loop, score hold, game over.
module render_scheduler
  import render_pkg::*;
#(
  parameter int unsigned N_LAYERS        = 6,
  parameter int unsigned TICK_DIV        = 833334,
  parameter int unsigned FRAMES_PER_STEP = 15,
  parameter int unsigned SCORE_HOLD      = 25000000,
  parameter int unsigned WIN_COUNT       = 5,
  parameter int unsigned WDOG            = 65535,
  parameter int unsigned SEL_W           = 5
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                game_start,
  input  logic                pause,
  input  logic [N_LAYERS-1:0] layer_en,
  input  logic [N_LAYERS-1:0] done_layer,
  input  logic                done_recipe,
  input  logic                done_erase,
  input  logic                done_score,
  input  logic                done_over,
  input  logic                end_req,
  input  logic [2:0]          caught_num,
  output logic                ld_recipe,
  output logic                go_erase,
  output logic                go_shift,
  output logic                ld_score,
  output logic                ld_game_over,
  output logic [N_LAYERS-1:0] go_layer,
  output logic [SEL_W-1:0]    pixel_sel,
  output logic                write_en,
  output logic                busy,
  output logic                err_timeout
);

  localparam int unsigned IDX_W  = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
  localparam int unsigned FRM_W  = $clog2(FRAMES_PER_STEP + 1);
  localparam int unsigned HOLD_W = (SCORE_HOLD > 1) ? $clog2(SCORE_HOLD) : 1;
  localparam int unsigned WD_W   = $clog2(WDOG + 1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [FRM_W-1:0]  frame_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [WD_W-1:0]   wdog_cnt;
  logic              tick;
  logic              end_seen;
  logic              wd_active;
  logic              wd_exp;
  logic              timeout;
  logic [IDX_W:0]    hit;
  int                search_lo;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .tick   (tick)
  );

  // Lowest enabled layer index at or above lo; MSB flags that one was found.
  function automatic logic [IDX_W:0] find_en(input logic [N_LAYERS-1:0] en, input int lo);
    find_en = '0;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (en[i] && (i >= lo)) find_en = {1'b1, IDX_W'(i)};
    end
  endfunction

  assign wd_active = (state == LOAD_RECIPE) || (state == ERASE) || (state == LAYER) ||
                     (state == SCORE) || (state == OVER);
  assign wd_exp    = (wdog_cnt == WD_W'(WDOG - 1));

  // Next state; an expiring watchdog acts as the awaited done, a real done takes priority.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    timeout   = 1'b0;
    search_lo = (state == GAP) ? int'(idx) + 1 : 0;
    hit       = find_en(layer_en, search_lo);
    case (state)
      MENU:        if (game_start) state_nxt = WAIT_REL;
      WAIT_REL:    if (!game_start) state_nxt = LOAD_RECIPE;
      LOAD_RECIPE: if (done_recipe || wd_exp) begin
        timeout   = !done_recipe;
        state_nxt = ERASE;
      end
      ERASE: if (done_erase || wd_exp) begin
        timeout   = !done_erase;
        state_nxt = hit[IDX_W] ? LAYER : FRAME_WAIT;
        if (hit[IDX_W]) idx_nxt = hit[IDX_W-1:0];
      end
      LAYER: if (done_layer[idx] || wd_exp) begin
        timeout   = !done_layer[idx];
        state_nxt = GAP;
      end
      GAP: begin
        state_nxt = hit[IDX_W] ? LAYER : CHECK;
        if (hit[IDX_W]) idx_nxt = hit[IDX_W-1:0];
      end
      CHECK:       state_nxt = (end_seen || end_req) ? SCORE : FRAME_WAIT;
      FRAME_WAIT:  if ((frame_cnt >= FRM_W'(FRAMES_PER_STEP)) && !pause) state_nxt = SHIFT;
      SHIFT:       state_nxt = (caught_num == 3'(WIN_COUNT)) ? SCORE : ERASE;
      SCORE: if (done_score || wd_exp) begin
        timeout   = !done_score;
        state_nxt = HOLD;
      end
      HOLD:        if (hold_cnt == HOLD_W'(SCORE_HOLD - 1)) state_nxt = OVER;
      OVER: if (done_over || wd_exp) begin
        timeout   = !done_over;
        state_nxt = MENU;
      end
      default:     state_nxt = MENU;
    endcase
  end

  // State, counters, and Moore outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= MENU;
      idx          <= '0;
      frame_cnt    <= '0;
      hold_cnt     <= '0;
      wdog_cnt     <= '0;
      end_seen     <= 1'b0;
      err_timeout  <= 1'b0;
      ld_recipe    <= 1'b0;
      go_erase     <= 1'b0;
      go_shift     <= 1'b0;
      ld_score     <= 1'b0;
      ld_game_over <= 1'b0;
      go_layer     <= '0;
      pixel_sel    <= '0;
      write_en     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      hold_cnt <= (state == HOLD) ? hold_cnt + 1'b1 : '0;
      wdog_cnt <= ((state_nxt != state) || !wd_active) ? '0 : wdog_cnt + 1'b1;

      if (state == SHIFT) frame_cnt <= '0;
      else if (tick && !pause && (frame_cnt < FRM_W'(FRAMES_PER_STEP))) frame_cnt <= frame_cnt + 1'b1;

      if ((state_nxt == ERASE) && (state != ERASE)) end_seen <= 1'b0;
      else if (end_req && ((state == ERASE) || (state == LAYER) || (state == GAP) || (state == CHECK)))
        end_seen <= 1'b1;

      if ((state_nxt == LOAD_RECIPE) && (state != LOAD_RECIPE)) err_timeout <= 1'b0;
      else if (timeout) err_timeout <= 1'b1;

      ld_recipe    <= (state_nxt == LOAD_RECIPE);
      go_erase     <= (state_nxt == ERASE);
      go_shift     <= (state_nxt == SHIFT);
      ld_score     <= (state_nxt == SCORE);
      ld_game_over <= (state_nxt == OVER);
      go_layer     <= (state_nxt == LAYER) ? (N_LAYERS'(1) << idx_nxt) : '0;
      write_en     <= (state_nxt == ERASE) || (state_nxt == LAYER) ||
                      (state_nxt == SCORE) || (state_nxt == OVER);
      busy         <= (state_nxt != MENU);
      case (state_nxt)
        ERASE:   pixel_sel <= SEL_W'(SEL_ERASE);
        LAYER:   pixel_sel <= SEL_W'(sel_layer(32'(idx_nxt)));
        SCORE:   pixel_sel <= SEL_W'(sel_score(N_LAYERS));
        OVER:    pixel_sel <= SEL_W'(sel_over(N_LAYERS));
        default: pixel_sel <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_render_scheduler.sv
// Bench for render_scheduler: acts as all clients and checks the handshake order against a frame-level model.
module tb_render_scheduler;

  localparam int unsigned N      = 3;
  localparam int unsigned TDIV   = 4;
  localparam int unsigned FPS    = 2;
  localparam int unsigned HOLDC  = 10;
  localparam int unsigned WIN    = 5;
  localparam int unsigned WDOGC  = 20;
  localparam int unsigned SW     = 3;

  localparam logic [5:0] ST_RECIPE = 6'b000001;
  localparam logic [5:0] ST_ERASE  = 6'b000010;
  localparam logic [5:0] ST_LAYER  = 6'b000100;
  localparam logic [5:0] ST_SHIFT  = 6'b001000;
  localparam logic [5:0] ST_SCORE  = 6'b010000;
  localparam logic [5:0] ST_OVER   = 6'b100000;

  logic          clk = 1'b0;
  logic          resetn, game_start, pause, end_req;
  logic [N-1:0]  layer_en, done_layer, go_layer;
  logic          done_recipe, done_erase, done_score, done_over;
  logic [2:0]    caught_num;
  logic          ld_recipe, go_erase, go_shift, ld_score, ld_game_over;
  logic [SW-1:0] pixel_sel;
  logic          write_en, busy, err_timeout;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic        exp_err = 1'b0;

  render_scheduler #(
    .N_LAYERS(N), .TICK_DIV(TDIV), .FRAMES_PER_STEP(FPS), .SCORE_HOLD(HOLDC),
    .WIN_COUNT(WIN), .WDOG(WDOGC), .SEL_W(SW)
  ) dut (
    .clk(clk), .resetn(resetn), .game_start(game_start), .pause(pause),
    .layer_en(layer_en), .done_layer(done_layer), .done_recipe(done_recipe),
    .done_erase(done_erase), .done_score(done_score), .done_over(done_over),
    .end_req(end_req), .caught_num(caught_num), .ld_recipe(ld_recipe),
    .go_erase(go_erase), .go_shift(go_shift), .ld_score(ld_score),
    .ld_game_over(ld_game_over), .go_layer(go_layer), .pixel_sel(pixel_sel),
    .write_en(write_en), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] strobes();
    strobes = {ld_game_over, ld_score, go_shift, |go_layer, go_erase, ld_recipe};
  endfunction

  // Wait (bounded) for the next client strobe and require it to be the expected one.
  task automatic wait_strobe(input string tag, input logic [5:0] exp, input int budget);
    int n = 0;
    while (strobes() == 6'd0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(strobes()), 64'(exp));
  endtask

  // Client answers: which 0 recipe, 1 erase, 2 layer idx, 3 score, 4 over.
  task automatic pulse_done(input int which, input int idx, input int lat);
    repeat (lat - 1) @(negedge clk);
    case (which)
      0: done_recipe = 1'b1;
      1: done_erase  = 1'b1;
      2: done_layer  = N'(1) << idx;
      3: done_score  = 1'b1;
      default: done_over = 1'b1;
    endcase
    @(negedge clk);
    done_recipe = 1'b0; done_erase = 1'b0; done_layer = '0;
    done_score  = 1'b0; done_over  = 1'b0;
  endtask

  task automatic start_round();
    game_start = 1'b1;
    repeat (2) @(negedge clk);
    check("wait_rel_busy", 64'(busy), 64'(1));
    check("wait_rel_idle", 64'(strobes()), 64'(0));
    game_start = 1'b0;
    wait_strobe("recipe_go", ST_RECIPE, 10);
    check("recipe_we", 64'(write_en), 64'(0));
    exp_err = 1'b0;
    check("recipe_err", 64'(err_timeout), 64'(0));
    pulse_done(0, 0, $urandom_range(1, 3));
  endtask

  task automatic score_seq();
    int n = 0;
    check("score_sel", 64'(pixel_sel), 64'(N + 1));
    check("score_we", 64'(write_en), 64'(1));
    end_req = 1'b1;
    pulse_done(3, 0, $urandom_range(1, 3));
    while (strobes() == 6'd0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("hold_len", 64'(n), 64'(HOLDC));
    check("over_go", 64'(strobes()), 64'(ST_OVER));
    check("over_sel", 64'(pixel_sel), 64'(N + 2));
    end_req = 1'b0;
    pulse_done(4, 0, $urandom_range(1, 3));
    check("menu_busy", 64'(busy), 64'(0));
    check("menu_idle", 64'(strobes()), 64'(0));
  endtask

  // One frame from the erase strobe to the shift or score strobe; wd_mode 1 = done on the last
  // watchdog cycle of layer 1, 2 = layer 1 never answers.
  task automatic run_frame(input logic [N-1:0] en, input bit do_end, input bit win,
                           input int wd_mode, output bit shifted);
    int n;
    logic [N-1:0] onehot;
    bit first = 1'b1;
    wait_strobe("erase_go", ST_ERASE, 60);
    check("erase_sel", 64'(pixel_sel), 64'(0));
    check("erase_we", 64'(write_en), 64'(1));
    check("err_flag", 64'(err_timeout), 64'(exp_err));
    layer_en   = en;
    caught_num = win ? 3'(WIN) : 3'($urandom_range(0, 4));
    pulse_done(1, 0, $urandom_range(1, 3));
    for (int i = 0; i < int'(N); i++) begin
      if (en[i]) begin
        onehot = N'(1) << i;
        wait_strobe("layer_go", ST_LAYER, 20);
        check("layer_onehot", 64'(go_layer), 64'(onehot));
        check("layer_sel", 64'(pixel_sel), 64'(i + 1));
        check("layer_we", 64'(write_en), 64'(1));
        if (i == 1 && wd_mode == 2) begin
          n = 0;
          while (go_layer == onehot && n < 100) begin
            n++;
            @(negedge clk);
          end
          check("wdog_len", 64'(n), 64'(WDOGC));
          exp_err = 1'b1;
        end else if (i == 1 && wd_mode == 1) begin
          repeat (WDOGC - 1) @(negedge clk);
          pulse_done(2, i, 1);
        end else begin
          if (first && do_end) begin
            end_req = 1'b1;
            @(negedge clk);
            end_req = 1'b0;
          end
          done_layer = ~onehot;
          done_erase = 1'b1;
          @(negedge clk);
          done_layer = '0;
          done_erase = 1'b0;
          pulse_done(2, i, $urandom_range(1, 3));
        end
        first = 1'b0;
        check("gap_idle", 64'({strobes(), write_en, pixel_sel}), 64'(0));
        check("gap_busy", 64'(busy), 64'(1));
        check("gap_err", 64'(err_timeout), 64'(exp_err));
      end
    end
    if (do_end) begin
      wait_strobe("end_score", ST_SCORE, 10);
      shifted = 1'b0;
    end else begin
      wait_strobe("shift_go", ST_SHIFT, 40);
      shifted = 1'b1;
    end
  endtask

  // Starts on the cycle go_shift is seen; runs an empty frame and times the next shift.
  task automatic pace_test(input bit with_pause);
    int n = 2;
    bit seen = 1'b0;
    layer_en   = '0;
    caught_num = 3'd0;
    pause      = with_pause;
    @(negedge clk);
    check("pace_erase", 64'(strobes()), 64'(ST_ERASE));
    pulse_done(1, 0, 1);
    if (with_pause) begin
      repeat (50 * TDIV) begin
        @(negedge clk);
        if (strobes() != 6'd0) seen = 1'b1;
      end
      check("pause_hold", 64'(seen), 64'(0));
      pause = 1'b0;
      n = 0;
    end
    while (strobes() == 6'd0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (with_pause) check("pause_resume", 64'(n >= 6 && n <= 9), 64'(1));
    else            check("pace_period", 64'(n >= 7 && n <= 10), 64'(1));
    check("pace_shift", 64'(strobes()), 64'(ST_SHIFT));
  endtask

  task automatic frame_step(input logic [N-1:0] en, input bit do_end, input bit win,
                            input int wd_mode, input int pace_mode, output bit ended);
    bit shifted;
    run_frame(en, do_end, win, wd_mode, shifted);
    if (shifted) begin
      if (pace_mode != 0) pace_test(pace_mode == 2);
      @(negedge clk);
      check("post_shift", 64'(strobes()), 64'((win && pace_mode == 0) ? ST_SCORE : ST_ERASE));
    end
    ended = !shifted || (win && pace_mode == 0);
    if (ended) score_seq();
  endtask

  initial begin
    bit ended;
    logic [N-1:0] en;
    bit win, do_end;
    int f;
    resetn = 1'b0; game_start = 1'b0; pause = 1'b0; end_req = 1'b0;
    layer_en = '0; done_layer = '0; done_recipe = 1'b0; done_erase = 1'b0;
    done_score = 1'b0; done_over = 1'b0; caught_num = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_strobes", 64'(strobes()), 64'(0));
    check("rst_out", 64'({pixel_sel, write_en, busy, err_timeout}), 64'(0));
    resetn = 1'b1;
    @(negedge clk);
    check("menu_idle_busy", 64'(busy), 64'(0));

    start_round();
    frame_step(3'b111, 1'b0, 1'b0, 0, 1, ended);
    frame_step(3'b101, 1'b0, 1'b0, 0, 0, ended);
    frame_step(3'b000, 1'b0, 1'b0, 0, 2, ended);
    frame_step(3'b111, 1'b0, 1'b0, 1, 0, ended);
    frame_step(3'b111, 1'b0, 1'b0, 2, 0, ended);
    frame_step(3'b111, 1'b0, 1'b0, 0, 0, ended);
    frame_step(3'b111, 1'b1, 1'b0, 0, 0, ended);
    check("end_round", 64'(ended), 64'(1));

    start_round();
    frame_step(3'b011, 1'b0, 1'b1, 0, 0, ended);
    check("win_round", 64'(ended), 64'(1));

    for (int r = 0; r < 4; r++) begin
      start_round();
      ended = 1'b0;
      f = 0;
      while (!ended && f < 8) begin
        en     = N'($urandom_range(0, 7));
        win    = (f >= 5) || ($urandom_range(0, 5) == 0);
        do_end = !win && (en != '0) && ($urandom_range(0, 3) == 0);
        frame_step(en, do_end, win, 0, 0, ended);
        f++;
      end
    end

    start_round();
    wait_strobe("rst_erase", ST_ERASE, 20);
    layer_en = 3'b001;
    pulse_done(1, 0, 1);
    wait_strobe("rst_layer", ST_LAYER, 10);
    check("rst_layer_oh", 64'(go_layer), 64'(3'b001));
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_go", 64'({go_layer, go_erase, write_en, busy}), 64'(0));
    check("midrst_sel", 64'(pixel_sel), 64'(0));
    resetn = 1'b1;
    @(negedge clk);
    check("midrst_menu", 64'(busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
